// File: rtl/lpc_io_cycle_ctrl.sv
// rtl/lpc_io_cycle_ctrl.sv - LPC peripheral 16-bit I/O cycle sequencer; optional long-wait SYNC via LPC_LONG_WAIT_EN
module lpc_io_cycle_ctrl #(
    parameter logic [15:0] BASE_ADDR   = 16'h0A00,
    parameter logic [15:0] ADDR_MASK   = 16'hFFF0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        LpcClock,
    input  logic        PciReset,
    input  logic        LpcFrame,
    input  logic [3:0]  RBusDo,
    output logic        eWBus,
    output logic [3:0]  WBusDi,
    output logic [15:0] IoAddr,
    output logic [7:0]  IoWrData,
    output logic        IoWr,
    output logic        IoRd,
    input  logic [7:0]  IoRdData,
    output logic        Busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CYC,
        ST_ADR3,
        ST_ADR2,
        ST_ADR1,
        ST_ADR0,
        ST_WD0,
        ST_WD1,
        ST_HTAR0,
        ST_HTAR1,
        ST_SYNC,
        ST_RD0,
        ST_RD1,
        ST_PTAR0,
        ST_PTAR1
    } state_t;

    state_t      state_q;
    logic        is_wr_q;
    logic [3:0]  rd_hi_q;
`ifdef LPC_LONG_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    logic [3:0]  rd_lo_q;
    logic [3:0]  wait_q;
`endif

    // Address as it will look once the current nibble is shifted in; the
    // claim decision in ADR0 must include the last nibble on the bus.
    logic [15:0] addr_next;
    logic        hit;
    assign addr_next = {IoAddr[11:0], RBusDo};
    assign hit       = ((addr_next ^ BASE_ADDR) & ADDR_MASK) == 16'h0000;

    // Cycle sequencer: every pad control and strobe is a registered output
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q  <= ST_IDLE;
            is_wr_q  <= 1'b0;
            rd_hi_q  <= 4'h0;
            eWBus    <= 1'b0;
            WBusDi   <= 4'hF;
            IoAddr   <= 16'h0000;
            IoWrData <= 8'h00;
            IoWr     <= 1'b0;
            IoRd     <= 1'b0;
            Busy     <= 1'b0;
`ifdef LPC_LONG_WAIT_EN
            rd_lo_q  <= 4'h0;
            wait_q   <= 4'h0;
`endif
        end else begin
            IoWr <= 1'b0;
            IoRd <= 1'b0;
            if (!LpcFrame) begin
                // LFRAME# wins in every state: abandon the cycle, release LAD,
                // and treat this clock as a potential START.
                eWBus  <= 1'b0;
                WBusDi <= 4'hF;
                if (RBusDo == 4'h0) begin
                    state_q <= ST_CYC;
                    Busy    <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                    Busy    <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        Busy <= 1'b0;
                    end
                    ST_CYC: begin
                        // Only I/O cycle types are claimed; memory/DMA/FW drop out
                        if (RBusDo[3:2] == 2'b00) begin
                            is_wr_q <= RBusDo[1];
                            state_q <= ST_ADR3;
                        end else begin
                            state_q <= ST_IDLE;
                            Busy    <= 1'b0;
                        end
                    end
                    ST_ADR3: begin
                        IoAddr  <= addr_next;
                        state_q <= ST_ADR2;
                    end
                    ST_ADR2: begin
                        IoAddr  <= addr_next;
                        state_q <= ST_ADR1;
                    end
                    ST_ADR1: begin
                        IoAddr  <= addr_next;
                        state_q <= ST_ADR0;
                    end
                    ST_ADR0: begin
                        IoAddr <= addr_next;
                        if (!hit) begin
                            state_q <= ST_IDLE;
                            Busy    <= 1'b0;
                        end else if (is_wr_q) begin
                            state_q <= ST_WD0;
                        end else begin
                            state_q <= ST_HTAR0;
                        end
                    end
                    ST_WD0: begin
                        IoWrData[3:0] <= RBusDo;
                        state_q       <= ST_WD1;
                    end
                    ST_WD1: begin
                        IoWrData[7:4] <= RBusDo;
                        state_q       <= ST_HTAR0;
                    end
                    ST_HTAR0: begin
                        // Strobe is visible during HTAR1, when address/data are final
                        IoWr    <= is_wr_q;
                        IoRd    <= ~is_wr_q;
                        state_q <= ST_HTAR1;
                    end
                    ST_HTAR1: begin
                        eWBus   <= 1'b1;
                        state_q <= ST_SYNC;
`ifdef LPC_LONG_WAIT_EN
                        WBusDi  <= 4'h6;
                        wait_q  <= WAIT_LOAD;
`else
                        WBusDi  <= 4'h0;
`endif
                    end
                    ST_SYNC: begin
`ifdef LPC_LONG_WAIT_EN
                        if (wait_q != 4'h0) begin
                            wait_q <= wait_q - 4'h1;
                            if (wait_q == 4'h1) begin
                                // Last long-wait clock: register file data is
                                // settled, capture it and signal ready.
                                WBusDi <= 4'h0;
                                if (!is_wr_q) begin
                                    rd_lo_q <= IoRdData[3:0];
                                    rd_hi_q <= IoRdData[7:4];
                                end
                            end
                        end else if (is_wr_q) begin
                            WBusDi  <= 4'hF;
                            state_q <= ST_PTAR0;
                        end else begin
                            WBusDi  <= rd_lo_q;
                            state_q <= ST_RD0;
                        end
`else
                        if (is_wr_q) begin
                            WBusDi  <= 4'hF;
                            state_q <= ST_PTAR0;
                        end else begin
                            // Register file answers one clock after IoRd
                            WBusDi  <= IoRdData[3:0];
                            rd_hi_q <= IoRdData[7:4];
                            state_q <= ST_RD0;
                        end
`endif
                    end
                    ST_RD0: begin
                        WBusDi  <= rd_hi_q;
                        state_q <= ST_RD1;
                    end
                    ST_RD1: begin
                        WBusDi  <= 4'hF;
                        state_q <= ST_PTAR0;
                    end
                    ST_PTAR0: begin
                        eWBus   <= 1'b0;
                        WBusDi  <= 4'hF;
                        state_q <= ST_PTAR1;
                    end
                    ST_PTAR1: begin
                        state_q <= ST_IDLE;
                        Busy    <= 1'b0;
                    end
                    default: begin
                        eWBus   <= 1'b0;
                        WBusDi  <= 4'hF;
                        state_q <= ST_IDLE;
                        Busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_cycle_ctrl.sv
// tb/tb_lpc_io_cycle_ctrl.sv - randomized self-checking bench for lpc_io_cycle_ctrl
module tb_lpc_io_cycle_ctrl;

    localparam logic [15:0] BASE = 16'h0A00;
    localparam logic [15:0] MASK = 16'hFFF0;
    localparam int          WCYC = 2;
`ifdef LPC_LONG_WAIT_EN
    localparam int NW = WCYC;
`else
    localparam int NW = 0;
`endif
    localparam int HOLD = (NW == 0) ? 1 : NW;

    logic        LpcClock = 1'b0;
    logic        PciReset;
    logic        LpcFrame;
    logic [3:0]  RBusDo;
    logic        eWBus;
    logic [3:0]  WBusDi;
    logic [15:0] IoAddr;
    logic [7:0]  IoWrData;
    logic        IoWr;
    logic        IoRd;
    logic [7:0]  IoRdData;
    logic        Busy;

    lpc_io_cycle_ctrl #(
        .BASE_ADDR  (BASE),
        .ADDR_MASK  (MASK),
        .WAIT_CYCLES(WCYC)
    ) dut (
        .LpcClock(LpcClock),
        .PciReset(PciReset),
        .LpcFrame(LpcFrame),
        .RBusDo  (RBusDo),
        .eWBus   (eWBus),
        .WBusDi  (WBusDi),
        .IoAddr  (IoAddr),
        .IoWrData(IoWrData),
        .IoWr    (IoWr),
        .IoRd    (IoRd),
        .IoRdData(IoRdData),
        .Busy    (Busy)
    );

    always #15 LpcClock = ~LpcClock;

    typedef struct {
        bit         en;
        logic [3:0] dat;
        bit         wr;
        bit         rd;
        bit         busy;
    } exp_t;

    exp_t        eq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          pending_start = 0;
    int          hold = 0;
    bit          rd_prev = 0;
    logic [7:0]  cur_rd;
    logic [15:0] cur_addr;
    logic [7:0]  cur_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void push(bit en, logic [3:0] dat, bit wr, bit rd, bit busy);
        exp_t e;
        e.en = en; e.dat = dat; e.wr = wr; e.rd = rd; e.busy = busy;
        eq.push_back(e);
    endfunction

    // One LPC clock: drive host side, advance, then emulate the register file
    task automatic tick(input logic frame, input logic [3:0] lad);
        LpcFrame = frame;
        RBusDo   = lad;
        @(posedge LpcClock);
        #1;
        if (hold != 0) begin
            hold--;
            if (hold == 0) IoRdData = 8'($urandom);
        end
        if (rd_prev) begin
            IoRdData = cur_rd;
            hold     = HOLD;
        end
        rd_prev = IoRd;
    endtask

    task automatic check_cycle(input exp_t e);
        chk("eWBus", eWBus, e.en);
        if (e.en) chk("WBusDi", WBusDi, e.dat);
        chk("IoWr", IoWr, e.wr);
        chk("IoRd", IoRd, e.rd);
        chk("Busy", Busy, e.busy);
        if (e.wr) begin
            chk("IoAddr@wr", IoAddr, cur_addr);
            chk("IoWrData@wr", IoWrData, cur_wd);
        end
        if (e.rd) chk("IoAddr@rd", IoAddr, cur_addr);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_eWBus"}, eWBus, 0);
        chk({pfx, "_WBusDi"}, WBusDi, 4'hF);
        chk({pfx, "_IoAddr"}, IoAddr, 0);
        chk({pfx, "_IoWrData"}, IoWrData, 0);
        chk({pfx, "_IoWr"}, IoWr, 0);
        chk({pfx, "_IoRd"}, IoRd, 0);
        chk({pfx, "_Busy"}, Busy, 0);
    endtask

    task automatic mid_reset();
        #4 PciReset = 1'b0;
        #2 check_reset_vals("async_rst");
        LpcFrame = 1'b1;
        RBusDo   = 4'hF;
        hold     = 0;
        rd_prev  = 0;
        @(negedge LpcClock);
        @(negedge LpcClock);
        PciReset = 1'b1;
        pending_start = 0;
    endtask

    // kind: 0 = I/O read, 1 = I/O write, 2 = non-I/O cycle type
    task automatic run_txn(input int kind, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rdv, input int abort_at, input int rst_at);
        logic [3:0] lad [0:15];
        bit hit;
        exp_t ab;
        cur_addr = addr;
        cur_wd   = wd;
        cur_rd   = rdv;
        hit = ((addr ^ BASE) & MASK) == 16'h0;
        for (int i = 0; i < 16; i++) lad[i] = 4'hF;
        lad[0] = 4'h0;
        lad[1] = (kind == 1) ? 4'h2 : (kind == 0) ? 4'h0 : 4'h4;
        lad[2] = addr[15:12]; lad[3] = addr[11:8]; lad[4] = addr[7:4]; lad[5] = addr[3:0];
        if (kind == 1) begin lad[6] = wd[3:0]; lad[7] = wd[7:4]; end

        eq.delete();
        push(0, 4'hF, 0, 0, 1);
        if (kind == 2) begin
            push(0, 4'hF, 0, 0, 0);
        end else begin
            repeat (4) push(0, 4'hF, 0, 0, 1);
            if (!hit) begin
                push(0, 4'hF, 0, 0, 0);
            end else begin
                if (kind == 1) repeat (2) push(0, 4'hF, 0, 0, 1);
                push(0, 4'hF, 0, 0, 1);
                push(0, 4'hF, kind == 1, kind == 0, 1);
                repeat (NW) push(1, 4'h6, 0, 0, 1);
                push(1, 4'h0, 0, 0, 1);
                if (kind == 0) begin
                    push(1, rdv[3:0], 0, 0, 1);
                    push(1, rdv[7:4], 0, 0, 1);
                end
                push(1, 4'hF, 0, 0, 1);
                push(0, 4'hF, 0, 0, 1);
                push(0, 4'hF, 0, 0, 0);
            end
        end

        for (int c = (pending_start ? 1 : 0); c < eq.size(); c++) begin
            if (c == abort_at) begin
                tick(1'b0, 4'h0);
                ab.en = 0; ab.dat = 4'hF; ab.wr = 0; ab.rd = 0; ab.busy = 1;
                check_cycle(ab);
                pending_start = 1;
                return;
            end
            tick((c == 0) ? 1'b0 : 1'b1, (c < 16) ? lad[c] : 4'hF);
            check_cycle(eq[c]);
            if (c == rst_at) begin
                mid_reset();
                return;
            end
        end
        pending_start = 0;
    endtask

    task automatic idle_cycles(input int n);
        exp_t e;
        e.en = 0; e.dat = 4'hF; e.wr = 0; e.rd = 0; e.busy = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 4'hF);
            check_cycle(e);
        end
    endtask

    initial begin
        int kind, ab, rs;
        logic [15:0] a;
        PciReset = 1'b0;
        LpcFrame = 1'b1;
        RBusDo   = 4'hF;
        IoRdData = 8'h00;
        #20 check_reset_vals("reset");
        @(negedge LpcClock);
        PciReset = 1'b1;
        idle_cycles(2);

        run_txn(1, 16'h0A05, 8'h5A, 8'h00, -1, -1);
        idle_cycles(1);
        run_txn(0, 16'h0A0C, 8'h00, 8'hC3, -1, -1);
        idle_cycles(1);
        run_txn(1, 16'h0B00, 8'h77, 8'h00, -1, -1);
        idle_cycles(1);
        run_txn(1, 16'h0A03, 8'h9E, 8'h00, 7, -1);
        run_txn(0, 16'h0A0A, 8'h00, 8'h4B, -1, -1);
        idle_cycles(1);
        run_txn(0, 16'h0A01, 8'h00, 8'hE1, -1, 8 + NW);
        run_txn(0, 16'h0A0F, 8'h00, 8'h3D, -1, -1);
        run_txn(2, 16'h0A00, 8'h00, 8'h00, -1, -1);

        for (int t = 0; t < 150; t++) begin
            kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do a = 16'($urandom); while (((a ^ BASE) & MASK) == 16'h0);
            end else begin
                a = (BASE & MASK) | (16'($urandom) & ~MASK);
            end
            ab = -1;
            rs = -1;
            if ($urandom_range(0, 5) == 0) ab = $urandom_range(1, 12);
            else if ($urandom_range(0, 19) == 0) rs = $urandom_range(0, 10);
            run_txn(kind, a, 8'($urandom), 8'($urandom), ab, rs);
            if (!pending_start) idle_cycles($urandom_range(0, 2));
        end
        if (pending_start) run_txn(0, 16'h0A02, 8'h00, 8'h5C, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
